// File: rtl/vr_lsu_seq.sv
// Vector load/store sequencer: issues one word access per cycle to a combinational-read data memory.
// Optional bounds check enabled by defining VR_LSU_BOUNDS_CHK_EN.
//
// state  | meaning
// IDLE   | waiting for START; latches the command
// RUN    | one element access per cycle
// DONE   | one-cycle completion pulse
module vr_lsu_seq #(
   parameter int VLEN = 4,
   parameter int DW   = 32,
   parameter int VLW  = $clog2(VLEN) + 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 OP,
   input  logic [31:0]          BASE,
   input  logic [31:0]          STRIDE,
   input  logic [VLW-1:0]       VL,
   input  logic [VLEN*DW-1:0]   VWD,
   output logic [VLEN*DW-1:0]   VRD,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [31:0]          MEM_ADDR,
   output logic                 MEM_RW,
   output logic [DW-1:0]        MEM_WD,
   input  logic [DW-1:0]        MEM_RD,
   output logic                 ERR
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [VLW-1:0] VLEN_W = VLW'(VLEN);

   logic [1:0]          state;
   logic                op_q;
   logic [31:0]         cur_addr;
   logic [31:0]         stride_q;
   logic [VLEN*DW-1:0]  vwd_q;
   logic [VLW-1:0]      vl_q;
   logic [VLW-1:0]      idx;
   logic [VLEN*DW-1:0]  vrd_q;
   logic [VLW-1:0]      vl_clamp;
   logic                elem_ok;

   assign vl_clamp = (VL > VLEN_W) ? VLEN_W : VL;

`ifdef VR_LSU_BOUNDS_CHK_EN
   logic err_q;

   assign elem_ok = (cur_addr < 32'd1024);
   assign ERR     = err_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         err_q <= 1'b0;
      else if (state == S_IDLE && START)
         err_q <= 1'b0;
      else if (state == S_RUN && !elem_ok)
         err_q <= 1'b1;
   end
`else
   assign elem_ok = 1'b1;
   assign ERR     = 1'b0;
`endif

   // Memory strobes decode from state so an async reset kills a write immediately.
   assign BUSY     = (state != S_IDLE);
   assign DONE     = (state == S_DONE);
   assign MEM_RW   = (state == S_RUN) && op_q && elem_ok;
   assign MEM_ADDR = (state == S_RUN) ? cur_addr : 32'd0;
   assign MEM_WD   = (state == S_RUN) ? vwd_q[idx*DW +: DW] : '0;
   assign VRD      = vrd_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= S_IDLE;
         op_q     <= 1'b0;
         cur_addr <= 32'd0;
         stride_q <= 32'd0;
         vwd_q    <= '0;
         vl_q     <= '0;
         idx      <= '0;
         vrd_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  op_q     <= OP;
                  cur_addr <= BASE;
                  stride_q <= STRIDE;
                  vwd_q    <= VWD;
                  vl_q     <= vl_clamp;
                  idx      <= '0;
                  if (!OP)
                     vrd_q <= '0;
                  state <= (vl_clamp == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (!op_q)
                  vrd_q[idx*DW +: DW] <= elem_ok ? MEM_RD : '0;
               cur_addr <= cur_addr + stride_q;
               idx      <= idx + 1'b1;
               if (idx == vl_q - 1'b1)
                  state <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vr_lsu_seq.sv
// Directed self-checking bench for vr_lsu_seq with a behavioural word memory.
module tb_vr_lsu_seq;
   localparam int VLEN = 4;
   localparam int DW   = 32;
   localparam int VLW  = 3;

   logic              CLK = 1'b0;
   logic              RST;
   logic              START;
   logic              OP;
   logic [31:0]       BASE;
   logic [31:0]       STRIDE;
   logic [VLW-1:0]    VL;
   logic [VLEN*DW-1:0] VWD;
   logic [VLEN*DW-1:0] VRD;
   logic              BUSY;
   logic              DONE;
   logic [31:0]       MEM_ADDR;
   logic              MEM_RW;
   logic [DW-1:0]     MEM_WD;
   logic [DW-1:0]     MEM_RD;
   logic              ERR;

   logic [31:0] mem [0:1023];
   logic        pre_we = 1'b0;
   logic [9:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   vr_lsu_seq #(.VLEN(VLEN), .DW(DW), .VLW(VLW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .OP(OP), .BASE(BASE), .STRIDE(STRIDE),
      .VL(VL), .VWD(VWD), .VRD(VRD), .BUSY(BUSY), .DONE(DONE), .MEM_ADDR(MEM_ADDR),
      .MEM_RW(MEM_RW), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD), .ERR(ERR)
   );

   assign MEM_RD = mem[MEM_ADDR[11:2]];

   always @(posedge CLK) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (MEM_RW)
         mem[MEM_ADDR[11:2]] <= MEM_WD;
   end

   // Called at a negedge; returns at the negedge of cycle 1 with START dropped.
   task automatic issue(input logic op, input logic [31:0] base, input logic [31:0] stride,
                        input logic [VLW-1:0] vl, input logic [VLEN*DW-1:0] vwd);
      OP = op; BASE = base; STRIDE = stride; VL = vl; VWD = vwd; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic poke(input int a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a[9:0]; pre_data = d;
      @(negedge CLK);
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", DONE); end
      checks++; if (MEM_RW !== 1'b0) begin errors++; $display("FAIL reset_rw got=%b exp=0", MEM_RW); end
      checks++; if (MEM_ADDR !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", MEM_ADDR); end
      checks++; if (MEM_WD !== 32'd0) begin errors++; $display("FAIL reset_wd got=%h exp=0", MEM_WD); end
      checks++; if (VRD !== '0) begin errors++; $display("FAIL reset_vrd got=%h exp=0", VRD); end
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ERR); end
   endtask

   task automatic test_load_basic();
      issue(1'b0, 32'h0, 32'd4, 3'd4, '0);
      for (int c = 1; c <= 5; c++) begin
         checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL load_busy c=%0d got=%b exp=1", c, BUSY); end
         checks++; if (DONE !== (c == 5)) begin errors++; $display("FAIL load_done c=%0d got=%b exp=%b", c, DONE, c == 5); end
         checks++; if (MEM_RW !== 1'b0) begin errors++; $display("FAIL load_rw c=%0d got=%b exp=0", c, MEM_RW); end
         if (c <= 4) begin
            checks++;
            if (MEM_ADDR !== 32'((c - 1) * 4)) begin
               errors++; $display("FAIL load_addr c=%0d got=%h exp=%h", c, MEM_ADDR, (c - 1) * 4);
            end
         end
         @(negedge CLK);
      end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL load_idle_busy got=%b exp=0", BUSY); end
      checks++;
      if (VRD !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         errors++; $display("FAIL load_vrd got=%h exp=%h", VRD, {32'd4, 32'd3, 32'd2, 32'd1});
      end
   endtask

   task automatic test_store_load();
      issue(1'b1, 32'h48, 32'd4, 3'd3, {32'h0, 32'hC, 32'hB, 32'hA});
      for (int c = 1; c <= 4; c++) begin
         if (c <= 3) begin
            checks++; if (MEM_RW !== 1'b1) begin errors++; $display("FAIL store_rw c=%0d got=%b exp=1", c, MEM_RW); end
            checks++;
            if (MEM_ADDR !== 32'(32'h48 + (c - 1) * 4)) begin
               errors++; $display("FAIL store_addr c=%0d got=%h exp=%h", c, MEM_ADDR, 32'h48 + (c - 1) * 4);
            end
         end else begin
            checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL store_done got=%b exp=1", DONE); end
            checks++; if (MEM_RW !== 1'b0) begin errors++; $display("FAIL store_done_rw got=%b exp=0", MEM_RW); end
         end
         @(negedge CLK);
      end
      checks++; if (mem[18] !== 32'hA) begin errors++; $display("FAIL store_w18 got=%h exp=a", mem[18]); end
      checks++; if (mem[19] !== 32'hB) begin errors++; $display("FAIL store_w19 got=%h exp=b", mem[19]); end
      checks++; if (mem[20] !== 32'hC) begin errors++; $display("FAIL store_w20 got=%h exp=c", mem[20]); end
      checks++;
      if (VRD !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         errors++; $display("FAIL store_vrd_hold got=%h exp=%h", VRD, {32'd4, 32'd3, 32'd2, 32'd1});
      end
      issue(1'b0, 32'h48, 32'd4, 3'd3, '0);
      repeat (4) @(negedge CLK);
      checks++;
      if (VRD !== {32'h0, 32'hC, 32'hB, 32'hA}) begin
         errors++; $display("FAIL reload_vrd got=%h exp=%h", VRD, {32'h0, 32'hC, 32'hB, 32'hA});
      end
   endtask

   task automatic test_neg_stride();
      issue(1'b0, 32'h20, 32'hFFFF_FFFC, 3'd4, '0);
      for (int c = 1; c <= 5; c++) begin
         if (c <= 4) begin
            checks++;
            if (MEM_ADDR !== 32'(32'h20 - (c - 1) * 4)) begin
               errors++; $display("FAIL neg_addr c=%0d got=%h exp=%h", c, MEM_ADDR, 32'h20 - (c - 1) * 4);
            end
         end else begin
            checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL neg_done got=%b exp=1", DONE); end
         end
         @(negedge CLK);
      end
      checks++;
      if (VRD !== {32'd6, 32'd7, 32'd8, 32'd9}) begin
         errors++; $display("FAIL neg_vrd got=%h exp=%h", VRD, {32'd6, 32'd7, 32'd8, 32'd9});
      end
   endtask

   task automatic test_vl_zero();
      issue(1'b1, 32'h10, 32'd4, 3'd0, {4{32'hDEAD}});
      checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL vl0_done got=%b exp=1", DONE); end
      checks++; if (MEM_RW !== 1'b0) begin errors++; $display("FAIL vl0_rw got=%b exp=0", MEM_RW); end
      @(negedge CLK);
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL vl0_done_end got=%b exp=0", DONE); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL vl0_busy got=%b exp=0", BUSY); end
      checks++; if (mem[4] !== 32'd5) begin errors++; $display("FAIL vl0_mem got=%h exp=5", mem[4]); end
      checks++;
      if (VRD !== {32'd6, 32'd7, 32'd8, 32'd9}) begin
         errors++; $display("FAIL vl0_vrd got=%h exp=%h", VRD, {32'd6, 32'd7, 32'd8, 32'd9});
      end
   endtask

   task automatic test_vl_clamp();
      int writes = 0;
      int done_c = 0;
      issue(1'b1, 32'h100, 32'd4, 3'd7, {32'h44, 32'h33, 32'h22, 32'h11});
      for (int c = 1; c <= 6; c++) begin
         if (MEM_RW === 1'b1) writes++;
         if (DONE === 1'b1 && done_c == 0) done_c = c;
         @(negedge CLK);
      end
      checks++; if (writes != 4) begin errors++; $display("FAIL clamp_writes got=%0d exp=4", writes); end
      checks++; if (done_c != 5) begin errors++; $display("FAIL clamp_done_cycle got=%0d exp=5", done_c); end
      checks++; if (mem[67] !== 32'h44) begin errors++; $display("FAIL clamp_w67 got=%h exp=44", mem[67]); end
      checks++; if (mem[68] !== 32'h5A5A) begin errors++; $display("FAIL clamp_w68 got=%h exp=5a5a", mem[68]); end
   endtask

   task automatic test_start_ignored();
      issue(1'b0, 32'h0, 32'd4, 3'd4, '0);
      for (int c = 1; c <= 5; c++) begin
         if (c <= 4) begin
            checks++;
            if (MEM_ADDR !== 32'((c - 1) * 4) || MEM_RW !== 1'b0) begin
               errors++; $display("FAIL ign_addr c=%0d got=%h/%b exp=%h/0", c, MEM_ADDR, MEM_RW, (c - 1) * 4);
            end
         end else begin
            checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL ign_done got=%b exp=1", DONE); end
         end
         if (c == 2) begin START = 1'b1; OP = 1'b1; BASE = 32'h200; VL = 3'd1; end
         if (c == 4) START = 1'b0;
         @(negedge CLK);
      end
      checks++;
      if (VRD !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         errors++; $display("FAIL ign_vrd got=%h exp=%h", VRD, {32'd4, 32'd3, 32'd2, 32'd1});
      end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL ign_busy got=%b exp=0", BUSY); end
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 32'h0, 32'd4, 3'd4, {32'h44, 32'h33, 32'h22, 32'h11});
      checks++; if (MEM_RW !== 1'b1) begin errors++; $display("FAIL rmid_rw1 got=%b exp=1", MEM_RW); end
      @(negedge CLK);
      checks++; if (MEM_ADDR !== 32'd4) begin errors++; $display("FAIL rmid_addr got=%h exp=4", MEM_ADDR); end
      @(negedge CLK);
      RST = 1'b1;
      #1;
      checks++; if (MEM_RW !== 1'b0) begin errors++; $display("FAIL rmid_rw got=%b exp=0", MEM_RW); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", BUSY); end
      checks++; if (VRD !== '0) begin errors++; $display("FAIL rmid_vrd got=%h exp=0", VRD); end
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      checks++; if (mem[0] !== 32'h11) begin errors++; $display("FAIL rmid_w0 got=%h exp=11", mem[0]); end
      checks++; if (mem[1] !== 32'h22) begin errors++; $display("FAIL rmid_w1 got=%h exp=22", mem[1]); end
      checks++; if (mem[2] !== 32'd3) begin errors++; $display("FAIL rmid_w2 got=%h exp=3", mem[2]); end
      checks++; if (mem[3] !== 32'd4) begin errors++; $display("FAIL rmid_w3 got=%h exp=4", mem[3]); end
   endtask

`ifdef VR_LSU_BOUNDS_CHK_EN
   task automatic test_bounds();
      poke(256, 32'h77);
      poke(257, 32'h88);
      issue(1'b1, 32'h3F8, 32'd4, 3'd4, {32'hD4, 32'hD3, 32'hD2, 32'hD1});
      for (int c = 1; c <= 5; c++) begin
         if (c <= 4) begin
            checks++;
            if (MEM_RW !== (c <= 2)) begin
               errors++; $display("FAIL oob_rw c=%0d got=%b exp=%b", c, MEM_RW, c <= 2);
            end
         end
         @(negedge CLK);
      end
      checks++; if (mem[254] !== 32'hD1) begin errors++; $display("FAIL oob_w254 got=%h exp=d1", mem[254]); end
      checks++; if (mem[255] !== 32'hD2) begin errors++; $display("FAIL oob_w255 got=%h exp=d2", mem[255]); end
      checks++; if (mem[256] !== 32'h77) begin errors++; $display("FAIL oob_w256 got=%h exp=77", mem[256]); end
      checks++; if (mem[257] !== 32'h88) begin errors++; $display("FAIL oob_w257 got=%h exp=88", mem[257]); end
      repeat (2) @(negedge CLK);
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL oob_err_sticky got=%b exp=1", ERR); end
      issue(1'b1, 32'h0, 32'd4, 3'd0, '0);
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL oob_err_clear got=%b exp=0", ERR); end
      @(negedge CLK);
   endtask
`endif

   initial begin
      RST = 1'b1; START = 1'b0; OP = 1'b0; BASE = '0; STRIDE = '0; VL = '0; VWD = '0;
      #2;
      test_reset();
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 9; i++) poke(i, 32'(i + 1));
      poke(68, 32'h5A5A);
      test_load_basic();
      test_store_load();
      test_neg_stride();
      test_vl_zero();
      test_vl_clamp();
      test_start_ignored();
      test_reset_mid();
`ifdef VR_LSU_BOUNDS_CHK_EN
      test_bounds();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
